// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the transaction layer and fifo_ctrl.
// The slave side is the controller; the master side issues push/pop and thresholds.
interface fifo_ctrl_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   th_alto;
    logic [ADDR_W:0]   th_bajo;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              valid_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    modport master (
        output push, pop, th_alto, th_bajo,
        input  wr_en, rd_en, wr_ptr, rd_ptr, valid_out, count,
        input  full, empty, almost_full, almost_empty, error
    );

    modport slave (
        input  push, pop, th_alto, th_bajo,
        output wr_en, rd_en, wr_ptr, rd_ptr, valid_out, count,
        output full, empty, almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller driving an external DEPTH x DATA_W register-file FIFO memory.
// Defining FIFO_CTRL_STICKY_ERR_EN makes error hold until reset instead of pulsing.
module fifo_ctrl #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input logic        clk,
    input logic        reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

    if (DEPTH != (1 << ADDR_W) || DATA_W == 0) begin : g_bad_cfg
        $error("fifo_ctrl: DEPTH must equal 2**ADDR_W and DATA_W must be non-zero");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    logic full, empty;
    logic push_ok, pop_ok, rejected;

    // Count is the sole source of full/empty; pointers alike cannot tell them apart.
    always_comb begin
        full     = (count_q == FullCnt);
        empty    = (count_q == '0);
        // A full FIFO refuses push even alongside a pop, so read/write never share an address.
        push_ok  = bus.push & ~full;
        pop_ok   = bus.pop & ~empty;
        rejected = (bus.push & full) | (bus.pop & empty);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        valid_d = pop_ok;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        error_d = error_q | rejected;
`else
        error_d = rejected;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.wr_en        = push_ok;
    assign bus.rd_en        = pop_ok;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.valid_out    = valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= bus.th_alto);
    assign bus.almost_empty = (count_q <= bus.th_bajo);
    assign bus.error        = error_q;
endmodule
